// File: rtl/alu_pkg.sv
// Shared ALU types: opcodes, flag and result-buffer entry layouts.
package alu_pkg;

  localparam int unsigned DATA_W     = 16;
  localparam int unsigned OPCODE_W   = 4;
  localparam int unsigned FLAGS_W    = 3;
  localparam int unsigned FIFO_DEPTH = 2;

  typedef enum logic [OPCODE_W-1:0] {
    OP_ADD    = 4'h0,
    OP_SUB    = 4'h1,
    OP_XOR    = 4'h2,
    OP_RED    = 4'h3,
    OP_SLL    = 4'h4,
    OP_SRA    = 4'h5,
    OP_ROR    = 4'h6,
    OP_PADDSB = 4'h7
  } opcode_e;

  typedef struct packed {
    logic n;
    logic z;
    logic v;
  } flags_t;

  typedef struct packed {
    opcode_e             opcode;
    logic [DATA_W-1:0]   result;
    flags_t              flags;
  } entry_t;

endpackage

// File: rtl/alu_flag_commit_if.sv
// Result handshake bundle between the add/sub datapath, the flag-commit buffer and its consumer.
interface alu_flag_commit_if;
  import alu_pkg::*;

  logic                in_valid;
  logic                in_ready;
  logic [OPCODE_W-1:0] in_opcode;
  logic [DATA_W-1:0]   in_sum;
  logic                in_ovfl;
  logic                out_valid;
  logic                out_ready;
  logic [DATA_W-1:0]   out_result;
  logic [OPCODE_W-1:0] out_opcode;

  modport master (
    output in_valid, in_opcode, in_sum, in_ovfl, out_ready,
    input  in_ready, out_valid, out_result, out_opcode
  );

  modport slave (
    input  in_valid, in_opcode, in_sum, in_ovfl, out_ready,
    output in_ready, out_valid, out_result, out_opcode
  );

endinterface

// File: rtl/alu_flag_commit_flag_update_logic.sv
// Next architectural N/Z/V from the current flags and a retiring entry; shared with branch forwarding.
module flag_update_logic
  import alu_pkg::*;
(
  input  flags_t  cur_flags,
  input  flags_t  entry_flags,
  input  opcode_e opcode,
  output flags_t  next_flags_c
);

  always_comb begin
    next_flags_c = cur_flags;
    case (opcode)
      OP_ADD, OP_SUB:                 next_flags_c   = entry_flags;
      OP_XOR, OP_SLL, OP_SRA, OP_ROR: next_flags_c.z = entry_flags.z;
      default:                        next_flags_c   = cur_flags;
    endcase
  end

endmodule

// File: rtl/alu_flag_commit.sv
// Two-entry result buffer that commits N/Z/V flags when the consumer takes the head.
// Optional ALU_SAT_STATS_EN adds a saturating count of retired ADD/SUB overflows.
module alu_flag_commit
  import alu_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  alu_flag_commit_if.slave     bus,
  input  logic                 flush,
`ifdef ALU_SAT_STATS_EN
  output logic [DATA_W-1:0]    sat_count,
`endif
  output logic [FLAGS_W-1:0]   flags
);

  localparam int unsigned CNT_W = 2;

  entry_t     mem_q [FIFO_DEPTH];
  logic       wr_ptr_q;
  logic       rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  flags_t     flags_q;
  entry_t     head;
  entry_t     new_entry;
  flags_t     next_flags_c;
  logic       push;
  logic       pop;

  assign head = mem_q[rd_ptr_q];

  assign bus.in_ready   = (count_q != CNT_W'(FIFO_DEPTH));
  assign bus.out_valid  = (count_q != '0);
  assign bus.out_result = head.result;
  assign bus.out_opcode = head.opcode;
  assign flags          = flags_q;

  // Flush outranks both handshakes in the same cycle.
  assign push = bus.in_valid && bus.in_ready && !flush;
  assign pop  = bus.out_valid && bus.out_ready && !flush;

  always_comb begin
    new_entry         = '0;
    new_entry.opcode  = opcode_e'(bus.in_opcode);
    new_entry.result  = bus.in_sum;
    new_entry.flags.n = bus.in_sum[DATA_W-1];
    new_entry.flags.z = (bus.in_sum == '0);
    new_entry.flags.v = bus.in_ovfl;
  end

  flag_update_logic u_flag_update (
    .cur_flags    (flags_q),
    .entry_flags  (head.flags),
    .opcode       (head.opcode),
    .next_flags_c (next_flags_c)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= '0;
      flags_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= new_entry;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
        flags_q  <= next_flags_c;
      end
      count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

`ifdef ALU_SAT_STATS_EN
  logic [DATA_W-1:0] sat_count_q;
  logic              sat_event;

  assign sat_event = pop && head.flags.v && (head.opcode == OP_ADD || head.opcode == OP_SUB);
  assign sat_count = sat_count_q;

  // Counter sticks at all-ones rather than wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      sat_count_q <= '0;
    end else if (sat_event && (sat_count_q != '1)) begin
      sat_count_q <= sat_count_q + DATA_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_alu_flag_commit.sv
// Directed self-checking bench for alu_flag_commit (sat_count checks only with ALU_SAT_STATS_EN).
module tb_alu_flag_commit;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic [2:0]  flags;
`ifdef ALU_SAT_STATS_EN
  logic [15:0] sat_count;
`endif
  int errors = 0;
  int checks = 0;

  alu_flag_commit_if bus ();

  alu_flag_commit dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .flush     (flush),
`ifdef ALU_SAT_STATS_EN
    .sat_count (sat_count),
`endif
    .flags     (flags)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [3:0] op, input logic [15:0] sum, input logic ov);
    bus.in_valid  = v;
    bus.in_opcode = op;
    bus.in_sum    = sum;
    bus.in_ovfl   = ov;
  endtask

  initial begin
    rst = 1'b1;
    flush = 1'b0;
    bus.out_ready = 1'b0;
    drive(1'b0, 4'h0, 16'h0000, 1'b0);
    tick();
    tick();
    chk("rst_out_valid", 16'(bus.out_valid), 16'd0);
    chk("rst_in_ready", 16'(bus.in_ready), 16'd1);
    chk("rst_flags", 16'(flags), 16'd0);
    chk("rst_out_result", bus.out_result, 16'h0000);
    chk("rst_out_opcode", 16'(bus.out_opcode), 16'd0);
    rst = 1'b0;

    // ADD zero result: visible next cycle, then Z commits on pop
    bus.out_ready = 1'b1;
    drive(1'b1, 4'h0, 16'h0000, 1'b0);
    tick();
    drive(1'b0, 4'h0, 16'h0000, 1'b0);
    chk("add0_out_valid", 16'(bus.out_valid), 16'd1);
    chk("add0_flags_before_pop", 16'(flags), 16'd0);
    tick();
    chk("add0_flags", 16'(flags), 16'b010);
    chk("add0_drained", 16'(bus.out_valid), 16'd0);

    // SUB overflow then XOR back-to-back
    drive(1'b1, 4'h1, 16'h8000, 1'b1);
    tick();
    drive(1'b1, 4'h2, 16'h0005, 1'b0);
    tick();
    drive(1'b0, 4'h0, 16'h0000, 1'b0);
    chk("sub_flags", 16'(flags), 16'b101);
    chk("xor_head_result", bus.out_result, 16'h0005);
    chk("xor_head_opcode", 16'(bus.out_opcode), 16'd2);
    tick();
    chk("xor_flags", 16'(flags), 16'b101);
    chk("xor_drained", 16'(bus.out_valid), 16'd0);

    // Backpressure: fill, hold third, then drain in order
    bus.out_ready = 1'b0;
    drive(1'b1, 4'h0, 16'h0001, 1'b0);
    tick();
    chk("fill1_in_ready", 16'(bus.in_ready), 16'd1);
    drive(1'b1, 4'h1, 16'h7FFF, 1'b1);
    tick();
    chk("fill2_in_ready", 16'(bus.in_ready), 16'd0);
    drive(1'b1, 4'h0, 16'h1234, 1'b0);
    tick();
    chk("full_hold_in_ready", 16'(bus.in_ready), 16'd0);
    chk("full_head", bus.out_result, 16'h0001);
    bus.out_ready = 1'b1;
    tick();
    chk("drain1_head", bus.out_result, 16'h7FFF);
    chk("drain1_flags", 16'(flags), 16'b000);
    chk("drain1_in_ready", 16'(bus.in_ready), 16'd1);
    tick();
    drive(1'b0, 4'h0, 16'h0000, 1'b0);
    chk("drain2_head", bus.out_result, 16'h1234);
    chk("drain2_flags", 16'(flags), 16'b001);
    chk("drain2_valid", 16'(bus.out_valid), 16'd1);
    tick();
    chk("drain3_flags", 16'(flags), 16'b000);
    chk("drain3_empty", 16'(bus.out_valid), 16'd0);

    // Flush at count=2 with concurrent input and pop
    bus.out_ready = 1'b0;
    drive(1'b1, 4'h0, 16'hFFFF, 1'b0);
    tick();
    drive(1'b1, 4'h1, 16'h0000, 1'b1);
    tick();
    chk("pre_flush_full", 16'(bus.in_ready), 16'd0);
    flush = 1'b1;
    bus.out_ready = 1'b1;
    drive(1'b1, 4'h0, 16'h8000, 1'b1);
    tick();
    flush = 1'b0;
    drive(1'b0, 4'h0, 16'h0000, 1'b0);
    chk("flush2_out_valid", 16'(bus.out_valid), 16'd0);
    chk("flush2_in_ready", 16'(bus.in_ready), 16'd1);
    chk("flush2_flags", 16'(flags), 16'b000);
    // Flush while in_ready=1 must still reject the input
    bus.out_ready = 1'b0;
    drive(1'b1, 4'h0, 16'hFFFF, 1'b1);
    tick();
    flush = 1'b1;
    bus.out_ready = 1'b1;
    drive(1'b1, 4'h1, 16'h0000, 1'b1);
    tick();
    flush = 1'b0;
    drive(1'b0, 4'h0, 16'h0000, 1'b0);
    chk("flush1_out_valid", 16'(bus.out_valid), 16'd0);
    chk("flush1_flags", 16'(flags), 16'b000);
    tick();
    chk("flush1_stays_empty", 16'(bus.out_valid), 16'd0);

    // count=1 simultaneous push and pop
    bus.out_ready = 1'b0;
    drive(1'b1, 4'h2, 16'h0000, 1'b1);
    tick();
    bus.out_ready = 1'b1;
    drive(1'b1, 4'h0, 16'h8000, 1'b1);
    tick();
    drive(1'b0, 4'h0, 16'h0000, 1'b0);
    bus.out_ready = 1'b0;
    chk("pp_out_valid", 16'(bus.out_valid), 16'd1);
    chk("pp_head", bus.out_result, 16'h8000);
    chk("pp_opcode", 16'(bus.out_opcode), 16'd0);
    chk("pp_flags", 16'(flags), 16'b010);
    chk("pp_in_ready", 16'(bus.in_ready), 16'd1);
    tick();
    chk("pp_count1_hold", bus.out_result, 16'h8000);
    bus.out_ready = 1'b1;
    tick();
    chk("pp_add_flags", 16'(flags), 16'b101);
    chk("pp_empty", 16'(bus.out_valid), 16'd0);

    // RED holds flags; SRA writes Z only
    drive(1'b1, 4'h3, 16'h0000, 1'b1);
    tick();
    drive(1'b0, 4'h0, 16'h0000, 1'b0);
    tick();
    chk("red_hold_flags", 16'(flags), 16'b101);
    drive(1'b1, 4'h5, 16'h0000, 1'b0);
    tick();
    drive(1'b0, 4'h0, 16'h0000, 1'b0);
    tick();
    chk("sra_z_flags", 16'(flags), 16'b111);

    // Reset mid-stream
    bus.out_ready = 1'b0;
    drive(1'b1, 4'h1, 16'h4321, 1'b0);
    tick();
    rst = 1'b1;
    bus.out_ready = 1'b1;
    drive(1'b1, 4'h0, 16'h0000, 1'b0);
    tick();
    rst = 1'b0;
    drive(1'b0, 4'h0, 16'h0000, 1'b0);
    chk("mrst_out_valid", 16'(bus.out_valid), 16'd0);
    chk("mrst_in_ready", 16'(bus.in_ready), 16'd1);
    chk("mrst_flags", 16'(flags), 16'd0);
    chk("mrst_out_result", bus.out_result, 16'h0000);
    chk("mrst_out_opcode", 16'(bus.out_opcode), 16'd0);

`ifdef ALU_SAT_STATS_EN
    chk("sat_reset", sat_count, 16'd0);
    bus.out_ready = 1'b1;
    drive(1'b1, 4'h0, 16'h7FFF, 1'b1);
    tick();
    tick();
    tick();
    drive(1'b1, 4'h0, 16'h0001, 1'b0);
    tick();
    drive(1'b0, 4'h0, 16'h0000, 1'b0);
    tick();
    chk("sat_three", sat_count, 16'd3);
    bus.out_ready = 1'b0;
    drive(1'b1, 4'h0, 16'h7FFF, 1'b1);
    tick();
    drive(1'b0, 4'h0, 16'h0000, 1'b0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("sat_flush_not_counted", sat_count, 16'd3);
    bus.out_ready = 1'b1;
    drive(1'b1, 4'h1, 16'h8000, 1'b1);
    repeat (65535) tick();
    drive(1'b0, 4'h0, 16'h0000, 1'b0);
    tick();
    tick();
    chk("sat_saturates", sat_count, 16'hFFFF);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
